// File: rtl/noise_seq_ctrl_pkg.sv
// Shared types and default sizes for the noise-injection run controller.
package noise_ctrl_pkg;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_WARM_W        = 8;
  localparam int DEF_DRAIN_TIMEOUT = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/noise_seq_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/noise_seq_ctrl.sv
// Run controller for the noise path: warm-up, bounded symbol issue, drain of
// returning samples, then done/err status with issued vs returned counts.
module noise_seq_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WARM_W        = DEF_WARM_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_num_samples,
  input  logic [WARM_W-1:0] cfg_warmup,
  input  logic [DATA_W-1:0] sym_in,
  input  logic              sym_in_valid,
  output logic              sym_in_ready,
  output logic              nw_en,
  output logic [DATA_W-1:0] nw_in,
  output logic              nw_in_valid,
  input  logic [DATA_W-1:0] nw_out,
  input  logic              nw_out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  returned_cnt
);

  // One timer serves both warm-up and drain, so it must hold either range.
  localparam int TMR_W = (WARM_W > $clog2(DRAIN_TIMEOUT)) ? WARM_W : $clog2(DRAIN_TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic               err_q, err_d;
  logic               aborted_q, aborted_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [TMR_W-1:0]   timer_cnt;
  logic               start_take;
  logic               abort_take;
  logic               ret_take;
  logic               warm_last;
  logic               drain_last;

  assign start_take = (state_q == ST_IDLE) && start && !abort;
  assign abort_take = (state_q != ST_IDLE) && abort;
  assign warm_last  = (timer_cnt + TMR_W'(1)) >= TMR_W'(warm_q);
  assign drain_last = timer_cnt == TMR_W'(DRAIN_TIMEOUT - 1);

  sat_counter #(.W(CNT_W)) u_issued (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (start_take),
    .inc_i (nw_in_valid),
    .cnt_o (issued_cnt)
  );

  sat_counter #(.W(CNT_W)) u_returned (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (start_take),
    .inc_i (ret_take),
    .cnt_o (returned_cnt)
  );

  // Held at zero in IDLE and RUN so each of WARMUP and DRAIN starts from 0.
  sat_counter #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i ((state_q == ST_IDLE) || (state_q == ST_RUN)),
    .inc_i ((state_q == ST_WARMUP) || (state_q == ST_DRAIN)),
    .cnt_o (timer_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_take) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (start_take) state_d = ST_WARMUP;
        ST_WARMUP: if (warm_last) state_d = ST_RUN;
        ST_RUN:    if (issued_cnt >= n_q) state_d = ST_DRAIN;
        ST_DRAIN:  if ((returned_cnt == issued_cnt) || drain_last) state_d = ST_DONE;
        ST_DONE:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    nw_en        = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    sym_in_ready = 1'b0;
    ret_take     = 1'b0;
    unique case (state_q)
      ST_IDLE:   busy = 1'b0;
      ST_WARMUP: nw_en = 1'b1;
      ST_RUN: begin
        nw_en        = 1'b1;
        sym_in_ready = issued_cnt < n_q;
        ret_take     = nw_out_valid;
      end
      ST_DRAIN: begin
        nw_en    = 1'b1;
        ret_take = nw_out_valid;
      end
      ST_DONE: begin
        done     = 1'b1;
        ret_take = nw_out_valid;
      end
      default: busy = 1'b0;
    endcase
  end

  assign nw_in       = sym_in;
  assign nw_in_valid = sym_in_valid && sym_in_ready;

  always_comb begin
    n_d         = n_q;
    warm_d      = warm_q;
    err_d       = err_q;
    aborted_d   = abort_take;
    out_valid_d = ret_take;
    out_data_d  = ret_take ? nw_out : out_data_q;
    if (start_take) begin
      n_d    = cfg_num_samples;
      warm_d = cfg_warmup;
      err_d  = 1'b0;
    end else if ((state_q == ST_DONE) && !abort) begin
      err_d = err_q | (returned_cnt != issued_cnt);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_q         <= '0;
      warm_q      <= '0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      n_q         <= n_d;
      warm_q      <= warm_d;
      err_q       <= err_d;
      aborted_q   <= aborted_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign err       = err_q;
  assign aborted   = aborted_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
